// File: rtl/baccarat_card_dealer_if.sv
// Card-load bus between the game controller
// and the card dealer.
interface baccarat_card_dealer_if;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       new_hand;
  logic       shoe_refill;
  logic       force_valid;
  logic [3:0] force_rank;
  logic [3:0] pcard1;
  logic [3:0] pcard2;
  logic [3:0] pcard3;
  logic [3:0] dcard1;
  logic [3:0] dcard2;
  logic [3:0] dcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [7:0] cards_left;
  logic       shoe_empty;
  logic       deal_error;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output new_hand, shoe_refill,
    output force_valid, force_rank,
    input  pcard1, pcard2, pcard3,
    input  dcard1, dcard2, dcard3,
    input  pscore, dscore,
    input  cards_left, shoe_empty, deal_error
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  new_hand, shoe_refill,
    input  force_valid, force_rank,
    output pcard1, pcard2, pcard3,
    output dcard1, dcard2, dcard3,
    output pscore, dscore,
    output cards_left, shoe_empty, deal_error
  );
endinterface

// File: rtl/baccarat_card_dealer.sv
// Multi-deck shoe with LFSR draw, per-rank depletion
// and baccarat scoring for six hand slots.
module baccarat_card_dealer #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic                   slow_clock,
  input logic                   reset,
  baccarat_card_dealer_if.slave bus
);
  localparam logic [3:0] FULL =
    4'(4 * NUM_DECKS);
  localparam logic [7:0] TOTAL =
    8'(52 * NUM_DECKS);
  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0) ? 16'h0001 : SEED;

  logic [15:0] lfsr;
  logic [3:0]  cnt  [13];
  logic [3:0]  eff  [13];
  logic [3:0]  slot [6];
  logic [7:0]  cards_left;
  logic        deal_error;
  logic [5:0]  ld;
  logic        strobe;
  logic        one_hot;
  logic        legal;
  logic        illegal;
  logic [3:0]  cand_idx;
  logic [3:0]  dealt_idx;
  logic [4:0]  p;
  logic        found;
  logic [4:0]  psum;
  logic [4:0]  dsum;

  function automatic logic [4:0] value(
    input logic [3:0] r
  );
    return (r >= 4'd1 && r <= 4'd9) ?
      {1'b0, r} : 5'd0;
  endfunction

  function automatic logic [3:0] mod10(
    input logic [4:0] s
  );
    logic [4:0] t;
    t = s;
    if (t >= 5'd20) t = t - 5'd20;
    else if (t >= 5'd10) t = t - 5'd10;
    return t[3:0];
  endfunction

  assign ld = {bus.load_dcard3, bus.load_dcard2,
               bus.load_dcard1, bus.load_pcard3,
               bus.load_pcard2, bus.load_pcard1};
  assign strobe  = |ld;
  assign one_hot = strobe &&
    ((ld & (ld - 6'd1)) == 6'd0);
  // new_hand swallows any strobe without a deal or error
  assign legal   = !bus.new_hand && one_hot &&
    (cards_left != 8'd0);
  assign illegal = !bus.new_hand && strobe && !legal;

  always_comb begin
    cand_idx = (lfsr[3:0] < 4'd13) ?
      lfsr[3:0] : lfsr[3:0] - 4'd13;
    if (bus.force_valid) begin
      if (bus.force_rank == 4'd0 ||
          bus.force_rank > 4'd13)
        cand_idx = 4'd0;
      else
        cand_idx = bus.force_rank - 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 13; i++)
      eff[i] = bus.shoe_refill ? FULL : cnt[i];
  end

  // Cyclic first-available scan starting at the candidate
  always_comb begin
    found     = 1'b0;
    dealt_idx = cand_idx;
    p         = '0;
    for (int k = 0; k < 13; k++) begin
      p = {1'b0, cand_idx} + 5'(k);
      if (p >= 5'd13) p = p - 5'd13;
      if (!found && eff[p[3:0]] != 4'd0) begin
        found     = 1'b1;
        dealt_idx = p[3:0];
      end
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      lfsr       <= SEED_EFF;
      cards_left <= TOTAL;
      deal_error <= 1'b0;
      for (int i = 0; i < 13; i++) cnt[i] <= FULL;
      for (int i = 0; i < 6; i++) slot[i] <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^
               lfsr[12] ^ lfsr[10]};
      if (illegal) deal_error <= 1'b1;
      for (int i = 0; i < 13; i++)
        cnt[i] <= eff[i] -
          {3'd0, legal && found &&
                 dealt_idx == 4'(i)};
      cards_left <=
        (bus.shoe_refill ? TOTAL : cards_left) -
        {7'd0, legal};
      if (bus.new_hand) begin
        for (int i = 0; i < 6; i++) slot[i] <= '0;
      end else if (legal) begin
        for (int i = 0; i < 6; i++)
          if (ld[i]) slot[i] <= dealt_idx + 4'd1;
      end
    end
  end

  assign psum = value(slot[0]) + value(slot[1]) +
                value(slot[2]);
  assign dsum = value(slot[3]) + value(slot[4]) +
                value(slot[5]);

  assign bus.pcard1     = slot[0];
  assign bus.pcard2     = slot[1];
  assign bus.pcard3     = slot[2];
  assign bus.dcard1     = slot[3];
  assign bus.dcard2     = slot[4];
  assign bus.dcard3     = slot[5];
  assign bus.pscore     = mod10(psum);
  assign bus.dscore     = mod10(dsum);
  assign bus.cards_left = cards_left;
  assign bus.shoe_empty = (cards_left == 8'd0);
  assign bus.deal_error = deal_error;
endmodule

// File: tb/tb_baccarat_card_dealer.sv
// Randomized bench for baccarat_card_dealer against
// a rank-count shoe model.
module tb_baccarat_card_dealer;
  localparam int          ND   = 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic slow_clock = 1'b0;
  logic reset      = 1'b0;
  int   checks     = 0;
  int   passed     = 0;

  baccarat_card_dealer_if bus ();

  baccarat_card_dealer #(
    .NUM_DECKS (ND),
    .SEED      (SEED)
  ) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus.slave)
  );

  always #5 slow_clock = ~slow_clock;

  logic [15:0] m_lfsr;
  int          m_cnt  [13];
  int          m_slot [6];
  bit          m_err;

  logic [41:0] dutv;
  assign dutv = {bus.pcard1, bus.pcard2, bus.pcard3,
                 bus.dcard1, bus.dcard2, bus.dcard3,
                 bus.pscore, bus.dscore,
                 bus.cards_left, bus.shoe_empty,
                 bus.deal_error};

  function automatic logic [5:0] strobes();
    return {bus.load_dcard3, bus.load_dcard2,
            bus.load_dcard1, bus.load_pcard3,
            bus.load_pcard2, bus.load_pcard1};
  endfunction

  function automatic int val(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  function automatic int shoe_total();
    int s = 0;
    foreach (m_cnt[i]) s += m_cnt[i];
    return s;
  endfunction

  function automatic logic [41:0] expv();
    int ps = 0;
    int ds = 0;
    int left;
    for (int i = 0; i < 3; i++) begin
      ps += val(m_slot[i]);
      ds += val(m_slot[i+3]);
    end
    left = shoe_total();
    return {4'(m_slot[0]), 4'(m_slot[1]),
            4'(m_slot[2]), 4'(m_slot[3]),
            4'(m_slot[4]), 4'(m_slot[5]),
            4'(ps % 10), 4'(ds % 10),
            8'(left), left == 0, m_err};
  endfunction

  task automatic model_edge();
    logic [5:0] ld;
    int n;
    int left;
    int cand;
    int r;
    int rk;
    ld = strobes();
    if (reset) begin
      m_lfsr = SEED;
      foreach (m_cnt[i]) m_cnt[i] = 4 * ND;
      foreach (m_slot[i]) m_slot[i] = 0;
      m_err = 0;
      return;
    end
    n    = $countones(ld);
    left = shoe_total();
    r    = int'(m_lfsr[3:0]);
    cand = (r < 13) ? r + 1 : r - 12;
    if (bus.force_valid)
      cand = (bus.force_rank == 0 ||
              bus.force_rank > 13) ?
             1 : int'(bus.force_rank);
    if (bus.new_hand)
      foreach (m_slot[i]) m_slot[i] = 0;
    else if (n > 1 || (n == 1 && left == 0))
      m_err = 1;
    if (bus.shoe_refill)
      foreach (m_cnt[i]) m_cnt[i] = 4 * ND;
    if (!bus.new_hand && n == 1 && left > 0) begin
      rk = 0;
      for (int k = 0; k < 13; k++) begin
        int c;
        c = ((cand - 1 + k) % 13) + 1;
        if (rk == 0 && m_cnt[c-1] > 0) rk = c;
      end
      for (int i = 0; i < 6; i++)
        if (ld[i]) m_slot[i] = rk;
      m_cnt[rk-1]--;
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13]
              ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic tick();
    model_edge();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic set_strobes(input logic [5:0] v);
    {bus.load_dcard3, bus.load_dcard2,
     bus.load_dcard1, bus.load_pcard3,
     bus.load_pcard2, bus.load_pcard1} = v;
  endtask

  task automatic idle();
    set_strobes(6'd0);
    bus.new_hand    = 1'b0;
    bus.shoe_refill = 1'b0;
    bus.force_valid = 1'b0;
    bus.force_rank  = 4'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // fr == 0 leaves the draw to the LFSR
  task automatic deal(input int s, input int fr);
    set_strobes(6'(1 << s));
    bus.force_valid = (fr != 0);
    bus.force_rank  = 4'(fr);
    tick();
    idle();
  endtask

  task automatic pulse_new_hand();
    bus.new_hand = 1'b1;
    tick();
    idle();
  endtask

  function automatic logic [3:0] dut_slot(
    input int s
  );
    case (s)
      0: return bus.pcard1;
      1: return bus.pcard2;
      2: return bus.pcard3;
      3: return bus.dcard1;
      4: return bus.dcard2;
      default: return bus.dcard3;
    endcase
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (dutv !== expv())
      $display("FAIL reset_state: got %h want %h",
               dutv, expv());
    else passed++;
    checks++;
    if (bus.cards_left !== 8'(52 * ND))
      $display("FAIL reset_left: got %0d want %0d",
               bus.cards_left, 52 * ND);
    else passed++;
  endtask

  task automatic test_forced_deal();
    do_reset();
    deal(0, 7);
    deal(3, 3);
    deal(1, 12);
    deal(4, 5);
    checks++;
    if ({bus.pcard1, bus.dcard1, bus.pcard2,
         bus.dcard2} !== 16'h73C5)
      $display("FAIL forced_slots: got %h want 73c5",
               {bus.pcard1, bus.dcard1, bus.pcard2,
                bus.dcard2});
    else passed++;
    checks++;
    if ({bus.pscore, bus.dscore} !== 8'h78)
      $display("FAIL forced_scores: got %h want 78",
               {bus.pscore, bus.dscore});
    else passed++;
    checks++;
    if (bus.cards_left !== 8'd48)
      $display("FAIL forced_left: got %0d want 48",
               bus.cards_left);
    else passed++;
  endtask

  task automatic test_depletion();
    int sl  [5] = '{0, 3, 0, 3, 0};
    int exp [5] = '{9, 9, 9, 9, 10};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      deal(sl[i], 9);
      checks++;
      if (dut_slot(sl[i]) !== 4'(exp[i]))
        $display("FAIL deplete_%0d: got %0d want %0d",
                 i, dut_slot(sl[i]), exp[i]);
      else passed++;
      if (i == 1 || i == 3) pulse_new_hand();
    end
    checks++;
    if (bus.cards_left !== 8'd47 ||
        m_cnt[8] != 0)
      $display("FAIL deplete_left: got %0d want 47",
               bus.cards_left);
    else passed++;
  endtask

  task automatic test_illegal();
    do_reset();
    deal(0, 4);
    set_strobes(6'b001001);
    tick();
    idle();
    checks++;
    if ({bus.pcard1, bus.dcard1, bus.cards_left,
         bus.deal_error} !== {4'd4, 4'd0, 8'd51,
                              1'b1})
      $display("FAIL illegal_dual: got %h want %h",
               {bus.pcard1, bus.dcard1,
                bus.cards_left, bus.deal_error},
               {4'd4, 4'd0, 8'd51, 1'b1});
    else passed++;
    deal(4, 0);
    deal(5, 2);
    checks++;
    if (bus.deal_error !== 1'b1 ||
        bus.cards_left !== 8'd49)
      $display("FAIL illegal_sticky: got %b/%0d want 1/49",
               bus.deal_error, bus.cards_left);
    else passed++;
    checks++;
    if (dutv !== expv())
      $display("FAIL illegal_model: got %h want %h",
               dutv, expv());
    else passed++;
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 52 * ND; i++) begin
      deal(0, 0);
      checks++;
      if (dutv !== expv())
        $display("FAIL drain_%0d: got %h want %h",
                 i, dutv, expv());
      else passed++;
    end
    checks++;
    if (bus.shoe_empty !== 1'b1)
      $display("FAIL drain_empty: got %b want 1",
               bus.shoe_empty);
    else passed++;
    deal(2, 0);
    checks++;
    if ({bus.pcard3, bus.deal_error,
         bus.cards_left} !== {4'd0, 1'b1, 8'd0})
      $display("FAIL empty_strobe: got %h want %h",
               {bus.pcard3, bus.deal_error,
                bus.cards_left},
               {4'd0, 1'b1, 8'd0});
    else passed++;
    bus.shoe_refill = 1'b1;
    tick();
    idle();
    checks++;
    if ({bus.cards_left, bus.shoe_empty} !==
        {8'(52 * ND), 1'b0})
      $display("FAIL refill: got %0d/%b want %0d/0",
               bus.cards_left, bus.shoe_empty,
               52 * ND);
    else passed++;
  endtask

  task automatic test_scores();
    int rk [6] = '{9, 8, 7, 13, 10, 1};
    do_reset();
    for (int i = 0; i < 6; i++) deal(i, rk[i]);
    checks++;
    if ({bus.pscore, bus.dscore} !== 8'h41)
      $display("FAIL scores: got %h want 41",
               {bus.pscore, bus.dscore});
    else passed++;
  endtask

  task automatic test_random();
    int pick;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 75)
        set_strobes(6'(1 << $urandom_range(0, 5)));
      else if (pick < 85)
        set_strobes(6'($urandom_range(0, 63)));
      else
        set_strobes(6'd0);
      bus.new_hand    = ($urandom_range(0, 19) == 0);
      bus.shoe_refill = ($urandom_range(0, 39) == 0);
      bus.force_valid = ($urandom_range(0, 2) == 0);
      bus.force_rank  = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (dutv !== expv())
        $display("FAIL random_%0d: got %h want %h",
                 c, dutv, expv());
      else passed++;
    end
    idle();
  endtask

  task automatic test_reset_midhand();
    logic [11:0] s1;
    logic [11:0] s2;
    do_reset();
    for (int i = 0; i < 3; i++) deal(i, 0);
    s1 = {bus.pcard1, bus.pcard2, bus.pcard3};
    checks++;
    if (dutv !== expv())
      $display("FAIL run1_model: got %h want %h",
               dutv, expv());
    else passed++;
    set_strobes(6'b000100);
    bus.shoe_refill = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    checks++;
    if (dutv !== {24'd0, 8'd0, 8'(52 * ND), 2'b00})
      $display("FAIL midhand_reset: got %h want %h",
               dutv,
               {24'd0, 8'd0, 8'(52 * ND), 2'b00});
    else passed++;
    for (int i = 0; i < 3; i++) deal(i, 0);
    s2 = {bus.pcard1, bus.pcard2, bus.pcard3};
    checks++;
    if (s2 !== s1 || dutv !== expv())
      $display("FAIL replay: got %h want %h",
               s2, s1);
    else passed++;
  endtask

  initial begin
    idle();
    test_reset();
    test_forced_deal();
    test_depletion();
    test_illegal();
    test_drain();
    test_scores();
    test_random();
    test_reset_midhand();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/baccarat_card_dealer.md
Name: baccarat_card_dealer

Overview:
- Responder side of the game controller's card-load interface.
- Each `load_*` strobe from the controller makes this block draw one card from a finite multi-deck shoe and latch it into the addressed hand slot.
- It returns per-slot ranks, baccarat hand scores (`pscore`/`dscore`) and the raw player third card (`pcard3`) to the controller and display logic.
- Card choice is pseudo-random (LFSR) with per-rank depletion tracking, so no rank is dealt more times than the shoe holds.

Parameters:
- NUM_DECKS, 1: decks in the shoe; legal range 1..3; each rank starts at 4*NUM_DECKS.
- SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- slow_clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_pcard1, load_pcard2, load_pcard3  in  1 each  player slot load strobes.
- load_dcard1, load_dcard2, load_dcard3  in  1 each  dealer slot load strobes.
- new_hand  in  1  clears all six slots; shoe contents kept.
- shoe_refill  in  1  restores every rank count to 4*NUM_DECKS.
- force_valid  in  1  test mode: use `force_rank` as the draw candidate instead of the LFSR.
- force_rank  in  4  test candidate rank, 1..13.
- pcard1, pcard2, pcard3  out  4 each  player slot ranks (0 = empty, 1..13 = A..K).
- dcard1, dcard2, dcard3  out  4 each  dealer slot ranks.
- pscore, dscore  out  4 each  hand scores, 0..9.
- cards_left  out  8  cards remaining in the shoe.
- shoe_empty  out  1  high when `cards_left` == 0.
- deal_error  out  1  sticky illegal-deal flag.

Behaviour:
- Reset (checked first, overrides all other inputs):
  - all slots = 0; `pscore` = `dscore` = 0.
  - every rank count = 4*NUM_DECKS; `cards_left` = 52*NUM_DECKS; `shoe_empty` = 0.
  - `deal_error` = 0; LFSR = SEED.
  - Reset mid-hand discards the hand and refills the shoe.
- LFSR:
  - 16-bit Fibonacci, advances every cycle when not in reset.
  - next = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
- Candidate rank:
  - r = l[3:0]; idx = r if r < 13, else r - 13; cand = idx + 1.
  - When `force_valid` = 1, cand = `force_rank`; `force_rank` values 0 or >13 treated as 1.
- Depletion search:
  - dealt rank = first rank with count > 0, scanning cand, cand+1, ..., 13, 1, ... cyclically.
  - The search is combinational over 13 ranks, so one card is available every cycle.
- Deal, on an edge where exactly one `load_*` is high and the shoe is non-empty:
  - addressed slot <= dealt rank.
  - that rank's count decrements; `cards_left` decrements.
  - Latency: slot and score outputs reflect the card in the cycle after the strobe edge.
- A strobe to an already-filled slot overwrites the slot and still consumes a card.
- Illegal deal (two or more strobes high in the same cycle, or any strobe while `shoe_empty`):
  - no slot or count changes.
  - `deal_error` <= 1, held until reset.
- `new_hand`:
  - clears all six slots at the edge.
  - If a strobe is high in the same cycle, `new_hand` wins and the strobe is ignored (no card consumed).
- `shoe_refill`:
  - restores counts at the edge.
  - Concurrent with a legal strobe: the deal happens from the refilled shoe (counts = full - 1 for the dealt rank).
  - Does not clear `deal_error`.
- Card value:
  - value(rank) = rank for 1..9; 0 for 0 and 10..13.
- Scores:
  - `pscore` = (value(pcard1) + value(pcard2) + value(pcard3)) mod 10; `dscore` likewise for the dealer slots.
  - Computed combinationally from slot registers.
  - Intermediate sum is 5 bits; max 27, reduced by subtracting 10 or 20.
- `shoe_empty` is combinational from `cards_left`.

Test Plan:
- Reset, then `force_valid` = 1 with `force_rank` = 7, 3, 12, 5 on `load_pcard1`, `load_dcard1`, `load_pcard2`, `load_dcard2` in successive cycles -> pcard1 = 7, dcard1 = 3, pcard2 = 12, dcard2 = 5; pscore = 7, dscore = 8; `cards_left` = 48.
- NUM_DECKS = 1, force rank 9 on five successive player/dealer loads with `new_hand` between hands -> first four deals give 9; fifth gives 10 (depletion search); count for rank 9 = 0.
- `load_pcard1` and `load_dcard1` high in the same cycle -> slots unchanged, `cards_left` unchanged, `deal_error` = 1 and stays 1 after later legal deals.
- Drain all 52 cards (NUM_DECKS = 1), then strobe `load_pcard3` -> `shoe_empty` = 1, pcard3 stays 0, `deal_error` = 1; `shoe_refill` -> `cards_left` = 52, `shoe_empty` = 0.
- Player ranks 9, 8, 7 -> pscore = 4 (24 mod 10); dealer ranks 13, 10, 1 -> dscore = 1.
- Assert reset mid-hand after three deals -> next cycle all slots = 0, scores = 0, `cards_left` = 52*NUM_DECKS, LFSR = SEED (two runs from reset produce identical unforced card sequences).
